alu_regfile: RTL and testbench
==============================

ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 Parameter WIDTH, default 16, data width of registers and ALU operands; all values below assume 16.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset_N  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-004 reg_write  input  1  register-file write enable.
REQ-005 read_addr1  input  2  register index for read port 1.
REQ-006 read_addr2  input  2  register index for read port 2.
REQ-007 write_addr  input  2  register index for the write port.
REQ-008 write_data  input  16  data written to write_addr.
REQ-009 read_data1  output  16  contents of register read_addr1.
REQ-010 read_data2  output  16  contents of register read_addr2.
REQ-011 alu_a  input  16  ALU operand A.
REQ-012 alu_b  input  16  ALU operand B.
REQ-013 alu_op  input  3  ALU operation select.
REQ-014 alu_result  output  16  ALU result.
REQ-015 overflow  output  1  signed-overflow flag for the current ALU operation.

Function
REQ-016 Register file SHALL hold four 16-bit registers R0-R3; R0 is an ordinary writable register, not hardwired to zero.
REQ-017 Write: at rising Clk with reg_write=1 and Reset_N=0, register write_addr SHALL take write_data; reg_write=0 leaves all registers unchanged.
REQ-018 Reads SHALL be combinational, zero-cycle latency; both ports are independent and may address the same register.
REQ-019 Read-during-write: when reg_write=1 and a read address equals write_addr, that read port SHALL return write_data in the same cycle (write-through bypass); other port unaffected.
REQ-020 ALU SHALL be purely combinational, zero latency, no state.
REQ-021 alu_op 0 ADD: A+B modulo 2^16.
REQ-022 alu_op 1 SUB: A-B modulo 2^16.
REQ-023 alu_op 2 AND: bitwise A&B.
REQ-024 alu_op 3 ORR: bitwise A|B.
REQ-025 alu_op 4 NOT: bitwise ~A; B ignored.
REQ-026 alu_op 5 TCP: two's complement ~A+1 modulo 2^16; B ignored.
REQ-027 alu_op 6 SHL: A logical left shift by 1, bit 0 = 0; B ignored.
REQ-028 alu_op 7 SHR: A arithmetic right shift by 1, bit 15 preserved; B ignored.
REQ-029 overflow for ADD SHALL be 1 iff A[15]==B[15] and result[15]!=A[15].
REQ-030 overflow for SUB SHALL be 1 iff A[15]!=B[15] and result[15]!=A[15].
REQ-031 overflow SHALL be 0 for ops 2-7, including TCP of 0x8000.
REQ-032 ALU and register file are independent; no internal path between them.

Reset
REQ-033 At rising Clk with Reset_N=1, all four registers SHALL become 0x0000; reset has priority over a simultaneous write, which is discarded.
REQ-034 During and after reset, read_data1/read_data2 SHALL reflect 0x0000 for every address until written (bypass in REQ-019 inactive while Reset_N=1).
REQ-035 ALU outputs SHALL not depend on reset.
REQ-036 Register contents after power-up without reset are undefined; bench SHALL reset first.

Verification
REQ-037 Reset, then read all addresses -> 0x0000 on both ports; reset asserted with reg_write=1, write_data=0x1234 -> register stays 0x0000.
REQ-038 Write R1=0xABCD, R2=0x0001, R3=0xFFFF on successive edges; read_addr1=1, read_addr2=3 -> 0xABCD, 0xFFFF; R0 still 0x0000.
REQ-039 reg_write=1, write_addr=2, write_data=0x5A5A, read_addr1=2 same cycle -> read_data1=0x5A5A before the edge; reg_write=0 -> no change.
REQ-040 ADD 0x7FFF+0x0001 -> 0x8000, overflow=1; ADD 0xFFFF+0x0001 -> 0x0000, overflow=0; SUB 0x8000-0x0001 -> 0x7FFF, overflow=1; SUB 0x0005-0x0007 -> 0xFFFE, overflow=0.
REQ-041 A=0xF0F0, B=0x0FF0: AND -> 0x00F0, ORR -> 0xFFF0, NOT -> 0x0F0F, TCP -> 0x0F10, overflow=0 for all.
REQ-042 SHL 0x8001 -> 0x0002; SHR 0x8002 -> 0xC001; SHR 0x0003 -> 0x0001; TCP 0x8000 -> 0x8000, overflow=0.

Source files
------------

// File: rtl/alu_regfile.sv
// Four-entry register file with write-through bypass, plus an independent
// combinational ALU with a signed-overflow flag.
module alu_regfile #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             reg_write,
    input  logic [1:0]       read_addr1,
    input  logic [1:0]       read_addr2,
    input  logic [1:0]       write_addr,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data1,
    output logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_result,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] regs_q [4];
    logic [WIDTH-1:0] regs_d [4];

    always_comb begin
        regs_d = regs_q;
        if (reg_write) begin
            regs_d[write_addr] = write_data;
        end
    end

    // Reset_N is active-high despite its name; it wins over a write.
    always_ff @(posedge Clk) begin
        if (Reset_N) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        read_data1 = regs_q[read_addr1];
        if (Reset_N) begin
            read_data1 = '0;
        end else if (reg_write && (read_addr1 == write_addr)) begin
            read_data1 = write_data;
        end
    end

    always_comb begin
        read_data2 = regs_q[read_addr2];
        if (Reset_N) begin
            read_data2 = '0;
        end else if (reg_write && (read_addr2 == write_addr)) begin
            read_data2 = write_data;
        end
    end

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = alu_a + alu_b;
    assign diff = alu_a - alu_b;

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        unique case (alu_op)
            3'd0: begin
                alu_result = sum;
                overflow   = (alu_a[MSB] == alu_b[MSB]) &&
                             (sum[MSB] != alu_a[MSB]);
            end
            3'd1: begin
                alu_result = diff;
                overflow   = (alu_a[MSB] != alu_b[MSB]) &&
                             (diff[MSB] != alu_a[MSB]);
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = ~alu_a;
            3'd5: alu_result = ~alu_a + 1'b1;
            3'd6: alu_result = {alu_a[MSB-1:0], 1'b0};
            3'd7: alu_result = {alu_a[MSB], alu_a[MSB:1]};
            default: alu_result = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: literal checks plus a per-cycle
// comparison against an arithmetic reference model.
module tb_alu_regfile;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        reg_write;
    logic [1:0]  read_addr1;
    logic [1:0]  read_addr2;
    logic [1:0]  write_addr;
    logic [15:0] write_data;
    logic [15:0] read_data1;
    logic [15:0] read_data2;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu_regfile #(.WIDTH(16)) dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .reg_write  (reg_write),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .overflow   (overflow)
    );

    always #5 Clk = ~Clk;

    // Reference model
    logic [15:0] mdl [4];
    bit          mdl_valid = 0;

    always @(posedge Clk) begin
        if (Reset_N) begin
            for (int i = 0; i < 4; i++) mdl[i] = 16'h0000;
            mdl_valid = 1;
        end else if (reg_write && mdl_valid) begin
            mdl[write_addr] = write_data;
        end
    end

    function automatic logic [15:0] exp_read(input logic [1:0] ra);
        if (Reset_N) return 16'h0000;
        if (reg_write && ra == write_addr) return write_data;
        return mdl[ra];
    endfunction

    function automatic void exp_alu(input logic [2:0] op,
                                    input logic [15:0] a,
                                    input logic [15:0] b,
                                    output logic [15:0] r,
                                    output logic v);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v  = 1'b0;
        s  = 0;
        case (op)
            3'd0: s = sa + sb;
            3'd1: s = sa - sb;
            3'd2: s = int'(a & b);
            3'd3: s = int'(a | b);
            3'd4: s = 65535 - int'(a);
            3'd5: s = -int'(a);
            3'd6: s = int'(a) * 2;
            default: s = sa >>> 1;
        endcase
        if (op <= 3'd1) v = (s > 32767) || (s < -32768);
        r = 16'(s);
    endfunction

    always @(negedge Clk) begin
        logic [15:0] er;
        logic        ev;
        exp_alu(alu_op, alu_a, alu_b, er, ev);
        checks++;
        if (alu_result !== er || overflow !== ev) begin
            errors++;
            $display("FAIL cyc_alu op=%0d act=%h/%b exp=%h/%b",
                     alu_op, alu_result, overflow, er, ev);
        end
        if (mdl_valid) begin
            checks++;
            if (read_data1 !== exp_read(read_addr1) ||
                read_data2 !== exp_read(read_addr2)) begin
                errors++;
                $display("FAIL cyc_rd act=%h,%h exp=%h,%h",
                         read_data1, read_data2,
                         exp_read(read_addr1), exp_read(read_addr2));
            end
        end
    end

    task automatic chk(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [2:0]  t_op  [12] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 7, 5};
    logic [15:0] t_a   [12] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'h0005,
                                16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                                16'h8001, 16'h8002, 16'h0003, 16'h8000};
    logic [15:0] t_b   [12] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007,
                                16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0FF0,
                                16'h1234, 16'h1234, 16'h1234, 16'h5555};
    logic [15:0] t_r   [12] = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFE,
                                16'h00F0, 16'hFFF0, 16'h0F0F, 16'h0F10,
                                16'h0002, 16'hC001, 16'h0001, 16'h8000};
    logic        t_v   [12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        Reset_N    = 1'b1;
        reg_write  = 1'b1;
        write_addr = 2'd0;
        write_data = 16'h1234;
        read_addr1 = 2'd0;
        read_addr2 = 2'd0;
        alu_a      = 16'h0;
        alu_b      = 16'h0;
        alu_op     = 3'd0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            read_addr1 = 2'(i);
            read_addr2 = 2'(3 - i);
            #1;
            chk("rst_rd1", {1'b0, read_data1}, 17'h0);
            chk("rst_rd2", {1'b0, read_data2}, 17'h0);
        end
        Reset_N   = 1'b0;
        reg_write = 1'b0;
        read_addr1 = 2'd0;
        #1;
        chk("rst_discard_r0", {1'b0, read_data1}, 17'h0);

        reg_write = 1'b1;
        write_addr = 2'd1; write_data = 16'hABCD; tick();
        write_addr = 2'd2; write_data = 16'h0001; tick();
        write_addr = 2'd3; write_data = 16'hFFFF; tick();
        reg_write = 1'b0;
        read_addr1 = 2'd1; read_addr2 = 2'd3; #1;
        chk("rd_r1", {1'b0, read_data1}, 17'hABCD);
        chk("rd_r3", {1'b0, read_data2}, 17'hFFFF);
        read_addr1 = 2'd0; read_addr2 = 2'd2; #1;
        chk("rd_r0", {1'b0, read_data1}, 17'h0000);
        chk("rd_r2", {1'b0, read_data2}, 17'h0001);

        tick();
        reg_write = 1'b1; write_addr = 2'd2; write_data = 16'h5A5A;
        read_addr1 = 2'd2; read_addr2 = 2'd1; #1;
        chk("byp_rd1", {1'b0, read_data1}, 17'h5A5A);
        chk("byp_rd2", {1'b0, read_data2}, 17'hABCD);
        tick();
        reg_write = 1'b0; write_data = 16'h1111; #1;
        chk("post_wr", {1'b0, read_data1}, 17'h5A5A);
        tick();
        chk("no_wr", {1'b0, read_data1}, 17'h5A5A);

        for (int i = 0; i < 12; i++) begin
            alu_op = t_op[i]; alu_a = t_a[i]; alu_b = t_b[i];
            #1;
            chk($sformatf("alu_%0d", i), {overflow, alu_result},
                {t_v[i], t_r[i]});
            tick();
        end

        // Reset mid-run clears contents and outputs while asserted
        Reset_N = 1'b1; read_addr1 = 2'd1; #1;
        chk("rst_mid_rd", {1'b0, read_data1}, 17'h0);
        tick();
        Reset_N = 1'b0; #1;
        chk("rst_mid_after", {1'b0, read_data1}, 17'h0);

        for (int i = 0; i < 300; i++) begin
            reg_write  = 1'($urandom);
            write_addr = 2'($urandom);
            write_data = 16'($urandom);
            read_addr1 = 2'($urandom);
            read_addr2 = 2'($urandom);
            alu_op     = 3'($urandom);
            alu_a      = 16'($urandom);
            alu_b      = 16'($urandom);
            Reset_N    = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
